// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and the round-robin search used by the 8-requester mux arbiter.
package rr_mux_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, GRANT} state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or after ptr, wrapping; scanned backwards so the nearest hit wins.
  function automatic rr_pick_t next_rr(input logic [N_REQ-1:0] req,
                                       input logic [SEL_W-1:0] ptr);
    rr_pick_t         r;
    logic [SEL_W-1:0] idx;
    r = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-bank to arbiter bundle: requests and data in, grant and muxed lane out.
interface rr_mux_arbiter_if;
  import rr_mux_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] din;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] sel;
  logic             valid;
  logic             dout;

  modport master (output req, din, input gnt, sel, valid, dout);
  modport slave  (input req, din, output gnt, sel, valid, dout);
endinterface

// File: rtl/rr_mux_arbiter_sel_mux8.sv
// Combinational 8:1 single-bit select.
module sel_mux8
  import rr_mux_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic [N_REQ-1:0] din_i,
  output logic             y_o
);
  assign y_o = din_i[sel_i];
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with capped grant tenure driving a shared 8:1 select lane.
module rr_mux_arbiter
  import rr_mux_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_arbiter_if.slave bus
);
  state_e           state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_q;
  logic             valid_q;

  logic             keep;
  logic [SEL_W-1:0] ptr_d;
  rr_pick_t         pick;
  logic             mux_y;

  // On release the search restarts just past the owner, so the owner is scanned last.
  always_comb begin
    keep  = (state_q == GRANT) && bus.req[sel_q] && (hold_q < CNT_W'(MAX_HOLD));
    ptr_d = (state_q == GRANT) ? sel_q + SEL_W'(1) : ptr_q;
    pick  = next_rr(bus.req, ptr_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (keep) begin
      hold_q <= hold_q + CNT_W'(1);
    end else begin
      ptr_q <= ptr_d;
      if (pick.found) begin
        state_q <= GRANT;
        sel_q   <= pick.idx;
        gnt_q   <= N_REQ'(1) << pick.idx;
        valid_q <= 1'b1;
        hold_q  <= CNT_W'(1);
      end else begin
        state_q <= IDLE;
        gnt_q   <= '0;
        valid_q <= 1'b0;
        hold_q  <= '0;
      end
    end
  end

  sel_mux8 u_mux (
    .sel_i (sel_q),
    .din_i (bus.din),
    .y_o   (mux_y)
  );

  assign bus.gnt   = gnt_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.dout  = valid_q & mux_y;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Two arbiters (MAX_HOLD 4 and 1) on shared stimulus, checked against an owner/pointer model.
module tb_rr_mux_arbiter;
  import rr_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_arbiter_if bus4();
  rr_mux_arbiter_if bus1();

  rr_mux_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  rr_mux_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  int n_assert = 0;
  int n_fail   = 0;
  int maxh    [2] = '{4, 1};
  int m_valid [2];
  int m_sel   [2];
  int m_hold  [2];
  int m_ptr   [2];
  logic [7:0] cur_din;

  // Model: an owner index with a tenure count; on release, look for the nearest
  // requester strictly after the owner, going around the ring of 8.
  task automatic model(input int u, input logic r, input logic [7:0] rq);
    int p;
    if (r) begin
      m_valid[u] = 0; m_sel[u] = 0; m_hold[u] = 0; m_ptr[u] = 0;
      return;
    end
    if (m_valid[u] != 0) begin
      if (rq[m_sel[u]] && m_hold[u] < maxh[u]) begin
        m_hold[u] = m_hold[u] + 1;
        return;
      end
      m_ptr[u] = (m_sel[u] + 1) % 8;
    end
    m_valid[u] = 0;
    m_hold[u]  = 0;
    for (int k = 0; k < 8; k++) begin
      p = (m_ptr[u] + k) % 8;
      if (rq[p]) begin
        m_valid[u] = 1; m_sel[u] = p; m_hold[u] = 1;
        break;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_unit(input int u, input logic [7:0] g, input logic [2:0] s,
                          input logic v, input logic d);
    logic [7:0] eg;
    logic       ed;
    eg = (m_valid[u] != 0) ? (8'd1 << m_sel[u]) : 8'd0;
    ed = (m_valid[u] != 0) ? cur_din[m_sel[u]] : 1'b0;
    check($sformatf("u%0d gnt t=%0t", u, $time), g, eg);
    check($sformatf("u%0d sel t=%0t", u, $time), {5'd0, s}, 8'(m_sel[u]));
    check($sformatf("u%0d valid t=%0t", u, $time), {7'd0, v}, 8'(m_valid[u]));
    check($sformatf("u%0d dout t=%0t", u, $time), {7'd0, d}, {7'd0, ed});
  endtask

  task automatic chk_all();
    chk_unit(0, bus4.gnt, bus4.sel, bus4.valid, bus4.dout);
    chk_unit(1, bus1.gnt, bus1.sel, bus1.valid, bus1.dout);
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] dn);
    rst = r;
    bus4.req = rq; bus1.req = rq;
    bus4.din = dn; bus1.din = dn;
    cur_din = dn;
    @(posedge clk);
    model(0, r, rq);
    model(1, r, rq);
    #1;
    chk_all();
  endtask

  task automatic hold_req(input logic [7:0] rq, input logic [7:0] dn, input int n);
    for (int i = 0; i < n; i++) step(1'b0, rq, dn);
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] dn;
    // Reset with everyone requesting, then first grant goes to 0.
    step(1'b1, 8'hFF, 8'h00);
    step(1'b1, 8'hFF, 8'h00);
    step(1'b0, 8'hFF, 8'hFF);
    // Single requester: capped tenure, immediate self re-grant.
    step(1'b1, 8'h00, 8'h00);
    hold_req(8'h10, 8'h10, 10);
    // Rotation 0,2,7,0.
    step(1'b1, 8'h00, 8'h00);
    hold_req(8'h85, 8'hA5, 20);
    // Wrap-around from 7 to 0.
    step(1'b1, 8'h00, 8'h00);
    hold_req(8'h80, 8'h80, 2);
    hold_req(8'h81, 8'h01, 6);
    // Early drop then go idle.
    step(1'b1, 8'h00, 8'h00);
    hold_req(8'h06, 8'h02, 3);
    hold_req(8'h04, 8'h04, 2);
    hold_req(8'h00, 8'hFF, 2);
    // Reset mid-grant.
    step(1'b1, 8'h00, 8'h00);
    hold_req(8'h20, 8'h20, 2);
    step(1'b1, 8'h21, 8'h21);
    hold_req(8'h21, 8'h01, 3);
    // Randomized traffic; dout must track live din between edges.
    for (int i = 0; i < 400; i++) begin
      rq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) rq = 8'h00;
      dn = 8'($urandom);
      step(($urandom_range(0, 39) == 0), rq, dn);
      dn = 8'($urandom);
      bus4.din = dn; bus1.din = dn; cur_din = dn;
      #1;
      chk_all();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8:1 1-bit selection datapath among 8 requesters.
- Each requester raises req[i] and presents a data bit on din[i]. The block grants one requester at a time and drives the 3-bit select, so dout carries din of the granted requester.
- Grant tenure is capped by a hold counter, which keeps requesters from starving.
- Sits between the requester bank and the shared output lane.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8; the select is 3 bits.
- MAX_HOLD, 4, maximum consecutive cycles one grant may last. Legal range 1..15.
- CNT_W, 4, width of the hold counter. Must hold MAX_HOLD.

Ports:
- clk     input   1  rising-edge clock.
- rst     input   1  synchronous, active-high reset.
- req     input   8  request vector; req[i] belongs to requester i.
- din     input   8  data bits; din[i] belongs to requester i.
- gnt     output  8  one-hot grant, registered.
- sel     output  3  index of the granted requester, registered.
- valid   output  1  high while a grant is active, registered.
- dout    output  1  equals din[sel] when valid=1, otherwise 0. Combinational from registered sel/valid.

Behaviour:
- Reset (rst sampled high at posedge):
  - state=IDLE, gnt=8'h00, sel=3'd0, valid=0, dout=0, hold_cnt=0, ptr=3'd0.
  - Reset overrides everything, including mid-grant; the grant is dropped at that edge.
- States:
  - IDLE: no grant.
  - GRANT: one requester owns the lane.
- Priority search:
  - Scan indices ptr, ptr+1, … wrapping mod 8.
  - The first index with req set wins.
  - ptr always equals (last granted index + 1) mod 8.
- IDLE -> GRANT:
  - If |req at a posedge, the winner w is registered: sel=w, gnt=1<<w, valid=1, hold_cnt=1.
  - Latency: 1 cycle from req to gnt.
- GRANT, continue:
  - Condition: req[sel]=1 and hold_cnt<MAX_HOLD.
  - Action: keep the grant and increment hold_cnt.
- GRANT, release:
  - Condition: req[sel]=0 or hold_cnt==MAX_HOLD.
  - Action: ptr=sel+1 (3-bit wrap, 7->0).
  - The search runs in the same cycle with the new ptr. If any req is set, re-grant at this edge with no bubble and hold_cnt=1. Otherwise go to IDLE: gnt=0, valid=0, sel holds its last value.
- Self re-grant: a requester whose hold expired is granted again only if no other req bit is set (it is scanned last).
- Request drop mid-grant: the grant is released at the next edge. dout follows din[sel] until then.
- din is not sampled. dout is a pure select of the live din.
- Invariants:
  - gnt is zero or one-hot.
  - gnt == (valid ? 1<<sel : 0).
  - hold_cnt never exceeds MAX_HOLD.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. Requesters rotate every cycle while several are active.

Decomposition:
- Shared package rr_mux_pkg holds:
  - state enum {IDLE, GRANT}
  - N_REQ=8, SEL_W=3
  - function next_rr(req, ptr) returning {found, index}
- One natural sub-module: sel_mux8, a combinational 8:1 select (sel[2:0], din[7:0] -> 1 bit), instantiated for dout and gated by valid.
- Arbiter FSM, pointer and hold counter live in rr_mux_arbiter.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req=8'hFF -> gnt=0, valid=0, sel=0, dout=0. Release rst -> next edge gnt=8'h01, sel=0.
- Single requester: req=8'h10 held, din=8'h10 -> gnt=8'h10, sel=4, dout=1.
  - With MAX_HOLD=4: grant lasts 4 cycles, then re-grant to 4 with no IDLE cycle, because no other requester is active.
- Round-robin rotation: req=8'h85 (0, 2, 7) held, MAX_HOLD=4, start ptr=0 -> sel sequence 0,2,7,0, each for 4 cycles, with back-to-back handover.
- Wrap-around: grant index 7, release -> ptr=0. With req=8'h81, the next grant is 0, not 7.
- Early drop: req=8'h06, index 1 granted. Drop req[1] after 2 cycles -> next edge gnt=8'h04, sel=2, hold_cnt=1. Drop all req -> IDLE, valid=0, dout=0.
- Reset mid-grant: during a grant to 5 with hold_cnt=2, assert rst for 1 cycle -> gnt=0, ptr=0. After release with req=8'h21, the grant goes to 0.
